// File: rtl/reg_file_wr_arb.sv
// Round-robin arbiter sharing the register file write port among NUM_REQ requesters.
// Optional: define REG_ZERO_EN to treat register 0 as hardwired zero (never written).
module reg_file_wr_arb #(
  parameter  int NUM_REQ    = 3,
  parameter  int REG_WIDTH  = 32,
  parameter  int ADDR_WIDTH = 4,
  localparam int NUM_REGS   = 1 << ADDR_WIDTH,
  localparam int GRANT_W    = ($clog2(NUM_REQ) > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_req_addr,
  input  logic [NUM_REQ*REG_WIDTH-1:0]  i_req_val,
  output logic [NUM_REQ-1:0]            o_req_ready,
  input  logic                          i_stall,
  output logic [ADDR_WIDTH-1:0]         o_reg_addr_w,
  output logic [REG_WIDTH-1:0]          o_reg_val_w,
  output logic                          o_write_en,
  output logic [GRANT_W-1:0]            o_grant_idx,
  output logic [NUM_REGS-1:0]           o_pending_mask
);

  logic [GRANT_W-1:0]    rr_ptr;
  logic                  out_valid;
  logic [ADDR_WIDTH-1:0] out_addr;
  logic [REG_WIDTH-1:0]  out_val;
  logic [GRANT_W-1:0]    out_idx;

  logic                  grant_found;
  logic [GRANT_W-1:0]    grant_idx;
  logic [GRANT_W-1:0]    next_ptr;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [REG_WIDTH-1:0]  sel_val;
  logic [NUM_REQ-1:0]    ready;
  logic                  addr_live;
  int                    idx;

  // Search starts at rr_ptr; explicit wrap keeps non-power-of-two NUM_REQ in range.
  always_comb begin
    ready       = '0;
    grant_found = 1'b0;
    grant_idx   = '0;
    sel_addr    = '0;
    sel_val     = '0;
    idx         = 0;
    if (!i_rst && !i_stall) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        idx = int'(rr_ptr) + i;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        if (!grant_found && i_req_valid[idx]) begin
          grant_found = 1'b1;
          grant_idx   = GRANT_W'(idx);
          sel_addr    = i_req_addr[idx*ADDR_WIDTH +: ADDR_WIDTH];
          sel_val     = i_req_val[idx*REG_WIDTH +: REG_WIDTH];
          ready[idx]  = 1'b1;
        end
      end
    end
  end

  assign next_ptr = (grant_idx == GRANT_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rr_ptr    <= '0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_val   <= '0;
      out_idx   <= '0;
    end else if (grant_found) begin
      // A grant implies no stall, so the previous entry drains in this same cycle.
      rr_ptr    <= next_ptr;
      out_valid <= 1'b1;
      out_addr  <= sel_addr;
      out_val   <= sel_val;
      out_idx   <= grant_idx;
    end else if (!i_stall) begin
      out_valid <= 1'b0;
    end
  end

`ifdef REG_ZERO_EN
  assign addr_live = (out_addr != '0);
`else
  assign addr_live = 1'b1;
`endif

  assign o_req_ready    = ready;
  assign o_write_en     = out_valid && addr_live && !i_stall && !i_rst;
  assign o_reg_addr_w   = out_addr;
  assign o_reg_val_w    = out_val;
  assign o_grant_idx    = out_idx;
  assign o_pending_mask = (out_valid && addr_live && !i_rst) ? (NUM_REGS'(1) << out_addr) : '0;

endmodule

// File: tb/tb_reg_file_wr_arb.sv
// Bench for reg_file_wr_arb: directed scenarios then random traffic against a cycle model.
module tb_reg_file_wr_arb;
  localparam int N  = 3;
  localparam int W  = 32;
  localparam int AW = 4;
  localparam int NR = 16;
  localparam int GW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            stall;
  logic [N-1:0]    req_valid;
  logic [AW-1:0]   ra [N];
  logic [W-1:0]    rv [N];
  logic [N*AW-1:0] req_addr;
  logic [N*W-1:0]  req_val;
  logic [N-1:0]    ready;
  logic [AW-1:0]   wr_addr;
  logic [W-1:0]    wr_val;
  logic            we;
  logic [GW-1:0]   gidx;
  logic [NR-1:0]   pmask;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  int            m_ptr;
  bit            m_v;
  logic [AW-1:0] m_addr;
  logic [W-1:0]  m_val;
  int            m_idx;
  int            m_grant;
  logic [N-1:0]  last_ready;

  // values seen at the last check point
  logic [N-1:0]  o_ready;
  logic          o_we;
  logic [AW-1:0] o_addr;
  logic [W-1:0]  o_val;
  logic [GW-1:0] o_idx;
  logic [NR-1:0] o_mask;

  always #5 clk = ~clk;

  always_comb begin
    req_addr = '0;
    req_val  = '0;
    for (int k = 0; k < N; k++) begin
      req_addr[k*AW +: AW] = ra[k];
      req_val[k*W +: W]    = rv[k];
    end
  end

  reg_file_wr_arb #(.NUM_REQ(N), .REG_WIDTH(W), .ADDR_WIDTH(AW)) dut (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .i_req_addr(req_addr),
    .i_req_val(req_val), .o_req_ready(ready), .i_stall(stall), .o_reg_addr_w(wr_addr),
    .o_reg_val_w(wr_val), .o_write_en(we), .o_grant_idx(gidx), .o_pending_mask(pmask)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_now();
    logic [N-1:0]  e_ready;
    logic [NR-1:0] e_mask;
    bit            live;
    bit            e_we;
    int            k;
    e_ready = '0;
    m_grant = -1;
    if (!rst && !stall) begin
      for (int i = 0; i < N; i++) begin
        k = (m_ptr + i) % N;
        if (m_grant < 0 && req_valid[k]) m_grant = k;
      end
    end
    if (m_grant >= 0) e_ready[m_grant] = 1'b1;
    live = 1'b1;
`ifdef REG_ZERO_EN
    if (m_addr == 0) live = 1'b0;
`endif
    e_we   = m_v && live && !stall && !rst;
    e_mask = '0;
    if (m_v && live && !rst) e_mask[m_addr] = 1'b1;
    o_ready = ready; o_we = we; o_addr = wr_addr; o_val = wr_val; o_idx = gidx; o_mask = pmask;
    chk("ready", 64'(ready), 64'(e_ready));
    chk("write_en", 64'(we), 64'(e_we));
    chk("pending_mask", 64'(pmask), 64'(e_mask));
    if (e_we) begin
      chk("wr_addr", 64'(wr_addr), 64'(m_addr));
      chk("wr_val", 64'(wr_val), 64'(m_val));
      chk("grant_idx", 64'(gidx), 64'(m_idx));
    end
    last_ready = e_ready;
  endtask

  task automatic model_edge();
    if (rst) begin
      m_ptr = 0; m_v = 0; m_addr = '0; m_val = '0; m_idx = 0;
    end else if (m_grant >= 0) begin
      m_v = 1; m_addr = ra[m_grant]; m_val = rv[m_grant]; m_idx = m_grant;
      m_ptr = (m_grant + 1) % N;
    end else if (!stall) begin
      m_v = 0;
    end
  endtask

  task automatic step();
    #2;
    check_now();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic clear_reqs();
    req_valid = '0;
    for (int k = 0; k < N; k++) begin ra[k] = '0; rv[k] = '0; end
  endtask

  task automatic do_reset();
    clear_reqs();
    rst = 1'b1; stall = 1'b0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic [N-1:0] seq [6];
    seq[0] = 3'b001; seq[1] = 3'b010; seq[2] = 3'b100;
    seq[3] = 3'b001; seq[4] = 3'b010; seq[5] = 3'b100;
    rst = 1'b1; stall = 1'b0; clear_reqs();
    @(posedge clk); #1;
    model_edge();

    // reset with every requester asking
    req_valid = '1;
    for (int k = 0; k < N; k++) begin ra[k] = AW'(k + 1); rv[k] = W'(k + 100); end
    for (int c = 0; c < 2; c++) begin
      step();
      chk("rst_ready", 64'(o_ready), 64'(0));
      chk("rst_we", 64'(o_we), 64'(0));
      chk("rst_mask", 64'(o_mask), 64'(0));
    end
    rst = 1'b0;
    step();
    chk("post_rst_addr", 64'(o_addr), 64'(0));
    chk("post_rst_val", 64'(o_val), 64'(0));
    chk("post_rst_idx", 64'(o_idx), 64'(0));
    chk("first_grant", 64'(o_ready), 64'(3'b001));

    // single requester, one-cycle latency
    do_reset();
    req_valid = 3'b010; ra[1] = 4'd5; rv[1] = 32'hDEADBEEF;
    step();
    chk("r1_ready", 64'(o_ready), 64'(3'b010));
    clear_reqs();
    step();
    chk("r1_we", 64'(o_we), 64'(1));
    chk("r1_addr", 64'(o_addr), 64'(5));
    chk("r1_val", 64'(o_val), 64'(32'hDEADBEEF));
    chk("r1_idx", 64'(o_idx), 64'(1));
    chk("r1_mask", 64'(o_mask), 64'(16'h0020));
    step();
    chk("r1_drained", 64'(o_we), 64'(0));

    // all valid: rotation and full throughput
    do_reset();
    req_valid = '1;
    for (int k = 0; k < N; k++) begin ra[k] = AW'(k + 2); rv[k] = W'(k * 7 + 1); end
    for (int c = 0; c < 6; c++) begin
      step();
      chk("rr_seq", 64'(o_ready), 64'(seq[c]));
      if (c > 0) chk("rr_we", 64'(o_we), 64'(1));
    end

    // stall holds the write, release issues it and grants in the same cycle
    do_reset();
    req_valid = 3'b001; ra[0] = 4'd3; rv[0] = 32'h33;
    step();
    clear_reqs();
    req_valid = 3'b100; ra[2] = 4'd9; rv[2] = 32'h99;
    stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("stall_we", 64'(o_we), 64'(0));
      chk("stall_mask", 64'(o_mask), 64'(16'h0008));
      chk("stall_ready", 64'(o_ready), 64'(0));
    end
    stall = 1'b0;
    step();
    chk("release_we", 64'(o_we), 64'(1));
    chk("release_addr", 64'(o_addr), 64'(3));
    chk("release_ready", 64'(o_ready), 64'(3'b100));
    clear_reqs();
    step();

    // reset discards a held write
    do_reset();
    req_valid = 3'b100; ra[2] = 4'd7; rv[2] = 32'h77;
    step();
    clear_reqs();
    rst = 1'b1;
    step();
    chk("rst_kill_we", 64'(o_we), 64'(0));
    chk("rst_kill_mask", 64'(o_mask), 64'(0));
    rst = 1'b0;
    req_valid = 3'b110; ra[1] = 4'd1; rv[1] = 32'h11; ra[2] = 4'd2; rv[2] = 32'h22;
    step();
    chk("rst_kill_we2", 64'(o_we), 64'(0));
    chk("rst_kill_mask2", 64'(o_mask), 64'(0));
    chk("after_rst_grant", 64'(o_ready), 64'(3'b010));

    // address 0
    do_reset();
    req_valid = 3'b001; ra[0] = 4'd0; rv[0] = 32'h1;
    step();
    chk("a0_ready", 64'(o_ready), 64'(3'b001));
    clear_reqs();
    step();
`ifdef REG_ZERO_EN
    chk("a0_we", 64'(o_we), 64'(0));
    chk("a0_mask", 64'(o_mask), 64'(0));
`else
    chk("a0_we", 64'(o_we), 64'(1));
    chk("a0_addr", 64'(o_addr), 64'(0));
    chk("a0_val", 64'(o_val), 64'(1));
`endif

    // random traffic; fields of a waiting requester stay stable
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < N; k++) begin
        if (!req_valid[k] || last_ready[k]) begin
          req_valid[k] = ($urandom_range(0, 2) != 0);
          ra[k] = AW'($urandom);
          rv[k] = $urandom;
        end
      end
      stall = ($urandom_range(0, 3) == 0);
      rst   = ($urandom_range(0, 49) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
